// File: rtl/pattern_scan_sequencer_pkg.sv
// Shared types and constants for the pattern scan sequencer and its pixel FIFO.
package pattern_scan_sequencer_pkg;

    localparam int COORD_W = 6;
    localparam int T_W     = 10;

    localparam logic [COORD_W-1:0] GRID_MAX = 6'd63;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [2:0]         rgb;
    } pixel_t;

    // True for the final raster coordinate (63,63).
    function automatic logic is_last_pixel(input logic [COORD_W-1:0] x,
                                           input logic [COORD_W-1:0] y);
        return (x == GRID_MAX) && (y == GRID_MAX);
    endfunction

endpackage

// File: rtl/pattern_pixel_fifo.sv
// First-word-fall-through pixel FIFO; head entry is visible while count is non-zero.
// DEPTH must be a power of two so the pointers wrap naturally.
module pattern_pixel_fifo
    import pattern_scan_sequencer_pkg::*;
#(
    parameter int  DEPTH        = 4,
    parameter type pixel_type_t = pixel_t
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  pixel_type_t            wr_data,
    input  logic                   rd_en,
    output pixel_type_t            rd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    pixel_type_t      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             do_wr_s;
    logic             do_rd_s;

    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign do_rd_s = rd_en && (count_r != {CNT_W{1'b0}});
    // A write into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_wr_s = wr_en && (!full_s || do_rd_s);

    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;

    // Storage array; cleared on reset so the payload reads as zero when empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/pattern_scan_sequencer.sv
// Raster-scans a 64x64 grid through a fixed-latency pattern pipeline and streams
// the results out through a valid/ready pixel FIFO.
// Optional feature macro: PATTERN_SCAN_CONTINUOUS_EN (frames restart without a new start).
module pattern_scan_sequencer
    import pattern_scan_sequencer_pkg::*;
#(
    parameter int PIPE_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [T_W-1:0]     t_step,
    output logic [COORD_W-1:0] pg_x,
    output logic [COORD_W-1:0] pg_y,
    output logic [T_W-1:0]     pg_t,
    output logic               pg_issue,
    input  logic               pg_r,
    input  logic               pg_g,
    input  logic               pg_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [2:0]         out_rgb,
    output logic               out_last,
    output logic               frame_done,
    output logic               busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    scan_state_t        state_r;
    scan_state_t        state_next_s;
    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_r;
    logic               all_issued_r;
    logic [T_W-1:0]     t_r;
    logic               pg_issue_r;
    logic [COORD_W-1:0] pg_x_r;
    logic [COORD_W-1:0] pg_y_r;
    logic [CNT_W-1:0]   in_flight_r;
    logic               frame_done_r;
    logic               busy_r;

    logic [PIPE_LATENCY-1:0] dl_valid_r;
    logic [COORD_W-1:0]      dl_x_r [PIPE_LATENCY];
    logic [COORD_W-1:0]      dl_y_r [PIPE_LATENCY];

    logic [CNT_W-1:0] fifo_count_s;
    pixel_t           fifo_wr_data_s;
    pixel_t           fifo_head_s;
    logic             out_valid_s;
    logic             pop_s;
    logic             arrive_s;
    logic [SUM_W-1:0] credit_sum_s;
    logic             credit_ok_s;
    logic             issue_next_s;
    logic             last_issued_s;
    logic             drained_s;
    logic             scan_restart_s;

    assign out_valid_s  = (fifo_count_s != {CNT_W{1'b0}});
    assign pop_s        = out_valid_s && out_ready;
    assign arrive_s     = dl_valid_r[PIPE_LATENCY-1];
    // Occupancy after this edge before any new issue: arrivals just move from
    // in-flight into the FIFO, a pop frees one slot.
    assign credit_sum_s = SUM_W'(in_flight_r) + SUM_W'(fifo_count_s) - SUM_W'(pop_s);
    assign credit_ok_s  = (credit_sum_s < SUM_W'(FIFO_DEPTH));
    assign issue_next_s = (state_r == SCAN) && !all_issued_r && credit_ok_s;
    assign last_issued_s  = pg_issue_r && is_last_pixel(pg_x_r, pg_y_r);
    assign drained_s      = (in_flight_r == {CNT_W{1'b0}}) && (fifo_count_s == {CNT_W{1'b0}});
    assign scan_restart_s = (state_r != SCAN) && (state_next_s == SCAN);

    // Next-state decode for the frame sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SCAN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SCAN: begin
                if (last_issued_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = SCAN;
                end
            end
            DRAIN: begin
                if (drained_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DONE: begin
`ifdef PATTERN_SCAN_CONTINUOUS_EN
                state_next_s = SCAN;
`else
                state_next_s = IDLE;
`endif
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Frame FSM with registered status outputs; t advances on entry to DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            t_r          <= {T_W{1'b0}};
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            frame_done_r <= (state_next_s == DONE);
            busy_r       <= (state_next_s != IDLE);
            if ((state_next_s == DONE) && (state_r != DONE)) begin
                t_r <= t_r + t_step;
            end
        end
    end

    // Raster counter, credit-gated issue register and in-flight accounting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_r          <= {COORD_W{1'b0}};
            y_r          <= {COORD_W{1'b0}};
            all_issued_r <= 1'b0;
            pg_issue_r   <= 1'b0;
            pg_x_r       <= {COORD_W{1'b0}};
            pg_y_r       <= {COORD_W{1'b0}};
            in_flight_r  <= {CNT_W{1'b0}};
        end else begin
            pg_issue_r  <= issue_next_s;
            in_flight_r <= in_flight_r + CNT_W'(issue_next_s) - CNT_W'(arrive_s);
            if (scan_restart_s) begin
                x_r          <= {COORD_W{1'b0}};
                y_r          <= {COORD_W{1'b0}};
                all_issued_r <= 1'b0;
            end else if (issue_next_s) begin
                pg_x_r <= x_r;
                pg_y_r <= y_r;
                if (x_r == GRID_MAX) begin
                    x_r <= {COORD_W{1'b0}};
                    y_r <= y_r + COORD_W'(1'b1);
                end else begin
                    x_r <= x_r + COORD_W'(1'b1);
                end
                if (is_last_pixel(x_r, y_r)) begin
                    all_issued_r <= 1'b1;
                end
            end
        end
    end

    // Coordinate tag delay line matching the pattern pipeline latency.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dl_valid_r <= {PIPE_LATENCY{1'b0}};
            for (int k = 0; k < PIPE_LATENCY; k++) begin
                dl_x_r[k] <= {COORD_W{1'b0}};
                dl_y_r[k] <= {COORD_W{1'b0}};
            end
        end else begin
            dl_valid_r[0] <= pg_issue_r;
            dl_x_r[0]     <= pg_x_r;
            dl_y_r[0]     <= pg_y_r;
            for (int k = 1; k < PIPE_LATENCY; k++) begin
                dl_valid_r[k] <= dl_valid_r[k-1];
                dl_x_r[k]     <= dl_x_r[k-1];
                dl_y_r[k]     <= dl_y_r[k-1];
            end
        end
    end

    // Join the returning pattern result with its delayed coordinate tag.
    always_comb begin
        fifo_wr_data_s     = '0;
        fifo_wr_data_s.x   = dl_x_r[PIPE_LATENCY-1];
        fifo_wr_data_s.y   = dl_y_r[PIPE_LATENCY-1];
        fifo_wr_data_s.rgb = {pg_r, pg_g, pg_b};
    end

    pattern_pixel_fifo #(
        .DEPTH        (FIFO_DEPTH),
        .pixel_type_t (pixel_t)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (arrive_s),
        .wr_data (fifo_wr_data_s),
        .rd_en   (pop_s),
        .rd_data (fifo_head_s),
        .count   (fifo_count_s)
    );

    assign pg_x       = pg_x_r;
    assign pg_y       = pg_y_r;
    assign pg_t       = t_r;
    assign pg_issue   = pg_issue_r;
    assign out_valid  = out_valid_s;
    assign out_x      = fifo_head_s.x;
    assign out_y      = fifo_head_s.y;
    assign out_rgb    = fifo_head_s.rgb;
    assign out_last   = out_valid_s && is_last_pixel(fifo_head_s.x, fifo_head_s.y);
    assign frame_done = frame_done_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_pattern_scan_sequencer.sv
// Self-checking bench for pattern_scan_sequencer: emulates the pattern pipeline
// and checks the issue and output streams against an index-based raster model.
module tb_pattern_scan_sequencer;

    localparam int PL = 2;
    localparam int FD = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [9:0] t_step = 10'd0;
    logic [5:0] pg_x;
    logic [5:0] pg_y;
    logic [9:0] pg_t;
    logic       pg_issue;
    logic       pg_r;
    logic       pg_g;
    logic       pg_b;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] out_x;
    logic [5:0] out_y;
    logic [2:0] out_rgb;
    logic       out_last;
    logic       frame_done;
    logic       busy;

    always #5 clock = ~clock;

    pattern_scan_sequencer #(.PIPE_LATENCY(PL), .FIFO_DEPTH(FD)) dut (
        .clock(clock), .reset(reset), .start(start), .t_step(t_step),
        .pg_x(pg_x), .pg_y(pg_y), .pg_t(pg_t), .pg_issue(pg_issue),
        .pg_r(pg_r), .pg_g(pg_g), .pg_b(pg_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_rgb(out_rgb), .out_last(out_last),
        .frame_done(frame_done), .busy(busy)
    );

    // Reference pattern: colour bits as plain arithmetic of (x, y, t).
    function automatic logic [2:0] pat(input int x, input int y, input int t);
        logic r;
        logic g;
        logic b;
        r = (((x + t) / 8) % 2) == 1;
        g = (((y + (t / 2)) / 4) % 2) == 1;
        b = (((x * y) + t) % 3) == 0;
        return {r, g, b};
    endfunction

    // Pattern pipeline emulation: result valid exactly PL cycles after issue, noise otherwise.
    logic       pv [PL];
    logic [5:0] px [PL];
    logic [5:0] py [PL];
    logic [9:0] pt [PL];
    logic [2:0] noise;
    logic [2:0] pg_res;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < PL; k++) begin
                pv[k] <= 1'b0;
                px[k] <= 6'd0;
                py[k] <= 6'd0;
                pt[k] <= 10'd0;
            end
            noise <= 3'd0;
        end else begin
            pv[0] <= pg_issue;
            px[0] <= pg_x;
            py[0] <= pg_y;
            pt[0] <= pg_t;
            for (int k = 1; k < PL; k++) begin
                pv[k] <= pv[k-1];
                px[k] <= px[k-1];
                py[k] <= py[k-1];
                pt[k] <= pt[k-1];
            end
            noise <= 3'($urandom);
        end
    end

    assign pg_res = pv[PL-1] ? pat(int'(px[PL-1]), int'(py[PL-1]), int'(pt[PL-1])) : noise;
    assign {pg_r, pg_g, pg_b} = pg_res;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          exp_idx = 0;
    int          issue_idx = 0;
    int          t_model = 0;
    int          frame_done_cnt = 0;
    int          busy_low_cnt = 0;
    int          ready_mode = 0;
    logic        hold_pending = 1'b0;
    logic [14:0] hold_payload = 15'd0;
    logic [11:0] last_issue_xy = 12'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge and check what the DUT presents.
    task automatic tick(input logic st);
        int ex;
        int ey;
        @(negedge clock);
        cyc++;
        start = st;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (hold_pending) begin
            chk("hold_stable", {out_valid, out_x, out_y, out_rgb}, {1'b1, hold_payload});
        end
        hold_pending = out_valid && !out_ready;
        hold_payload = {out_x, out_y, out_rgb};
        if (pg_issue) begin
            ex = issue_idx % 64;
            ey = issue_idx / 64;
            chk("issue_xyt", {pg_x, pg_y, pg_t}, {6'(ex), 6'(ey), 10'(t_model)});
            last_issue_xy = {pg_x, pg_y};
            issue_idx++;
        end
        if (out_valid && out_ready) begin
            ex = exp_idx % 64;
            ey = exp_idx / 64;
            chk("pixel", {out_x, out_y, out_rgb, out_last},
                {6'(ex), 6'(ey), pat(ex, ey, t_model), (exp_idx == 4095)});
            exp_idx++;
        end
        if (!busy) busy_low_cnt++;
        if (frame_done) begin
            chk("frame_complete", {issue_idx, exp_idx}, {32'd4096, 32'd4096});
            frame_done_cnt++;
            t_model = (t_model + int'(t_step)) % 1024;
            exp_idx = 0;
            issue_idx = 0;
        end
    endtask

    task automatic run_frame(input int budget);
        int f0;
        int n;
        f0 = frame_done_cnt;
        n = 0;
        while ((frame_done_cnt == f0) && (n < budget)) begin
            tick(1'b0);
            n++;
        end
        chk("frame_timeout", 64'(frame_done_cnt != f0), 64'd1);
    endtask

    initial begin
        int n;
        int issue_cyc;
        int valid_cyc;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_state", {pg_issue, out_valid, out_last, frame_done, busy, pg_x, pg_y, pg_t}, 64'd0);
        reset = 1'b1;
        repeat (5) tick(1'b0);
        chk("idle_quiet", {busy, pg_issue, out_valid, 32'(issue_idx)}, 64'd0);

`ifdef PATTERN_SCAN_CONTINUOUS_EN
        // Continuous frames from one start
        t_step = 10'd16;
        ready_mode = 0;
        tick(1'b1);
        busy_low_cnt = 0;
        repeat (3) run_frame(10000);
        chk("cont_frames", 64'(frame_done_cnt), 64'd3);
        tick(1'b0);
        chk("cont_t48", {54'd0, pg_t}, 64'd48);
        chk("cont_busy", 64'(busy_low_cnt), 64'd0);
`else
        // Frame 1: full throughput, t=0
        t_step = 10'd16;
        ready_mode = 0;
        tick(1'b1);
        n = 0;
        while (!pg_issue && (n < 20)) begin tick(1'b0); n++; end
        issue_cyc = cyc;
        while (!out_valid && (n < 40)) begin tick(1'b0); n++; end
        valid_cyc = cyc;
        chk("fwft_latency", 64'(valid_cyc - issue_cyc), 64'(PL + 1));
        run_frame(10000);
        tick(1'b0);
        tick(1'b0);
        chk("s1_idle", {busy, frame_done, pg_issue, 32'(frame_done_cnt)}, 64'd1);
        chk("t_after_s1", {54'd0, pg_t}, 64'd16);

        // Frame 2: sink stalled, only FIFO_DEPTH results accepted
        ready_mode = 1;
        tick(1'b1);
        repeat (40) tick(1'b0);
        chk("stall_issued", 64'(issue_idx), 64'(FD));
        chk("stall_no_output", 64'(exp_idx), 64'd0);
        chk("stall_head", {out_valid, pg_issue, out_x, out_y}, {1'b1, 1'b0, 6'd0, 6'd0});
        ready_mode = 0;
        n = 0;
        while ((issue_idx <= FD) && (n < 50)) begin tick(1'b0); n++; end
        chk("resume_xy", {52'd0, last_issue_xy}, {52'd0, 6'd4, 6'd0});
        run_frame(10000);

        // Frame 3: random backpressure
        ready_mode = 2;
        tick(1'b1);
        run_frame(20000);
        chk("s3_frames", 64'(frame_done_cnt), 64'd3);
        tick(1'b0);

        // Reset in the middle of a frame at pixel (10,20)
        t_step = 10'd1020;
        tick(1'b1);
        n = 0;
        while ((exp_idx <= (20 * 64 + 10)) && (n < 8000)) begin tick(1'b0); n++; end
        chk("reach_10_20", 64'(exp_idx), 64'(20 * 64 + 11));
        reset = 1'b0;
        #1;
        chk("reset_midframe", {pg_issue, pg_x, pg_y, pg_t, out_valid, out_x, out_y, out_rgb,
                               out_last, frame_done, busy}, 64'd0);
        t_model = 0;
        exp_idx = 0;
        issue_idx = 0;
        hold_pending = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (4) tick(1'b0);
        chk("post_reset_idle", {busy, pg_issue, out_valid, 32'(issue_idx)}, 64'd0);
        ready_mode = 0;
        tick(1'b1);
        run_frame(10000);
        tick(1'b0);
        chk("t_1020", {54'd0, pg_t}, 64'd1020);

        // Start pulses during SCAN are ignored; t wraps 1020+6 -> 2
        t_step = 10'd6;
        tick(1'b1);
        repeat (100) tick(1'b0);
        tick(1'b1);
        repeat (50) tick(1'b0);
        tick(1'b1);
        run_frame(10000);
        tick(1'b0);
        tick(1'b0);
        chk("s5_frames", 64'(frame_done_cnt), 64'd5);
        chk("t_wrap", {54'd0, pg_t}, 64'd2);
        chk("s5_idle", {busy, pg_issue}, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
